// File: rtl/diff_backprop_pkg.sv
// Shared types for the diff back-propagation receiver.
//   state_e  : emitter FSM states
//   bundle_t : scalar part of one captured bundle. The diff vectors are
//              parameter-sized, so the top appends them to this record
//              when it writes the buffer.
package diff_backprop_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  typedef struct packed {
    logic [31:0] layer;
    logic [31:0] row;
    logic        backprop_cost;
    logic [31:0] dense_type;
  } bundle_t;

endpackage

// File: rtl/diff_backprop_fifo.sv
// Small circular buffer of bundle entries for diff_backprop_rx.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i, wdata_i     : write request and entry
//   pop_i, rdata_o      : drop the head entry; rdata_o always shows the head
//   full_o, empty_o     : occupancy flags
//   count_o             : number of entries held
// A push while full is accepted when a pop happens in the same cycle.
module diff_backprop_fifo #(
  parameter int unsigned depth = 2,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);

  logic [Width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/diff_backprop_rx.sv
// Receives diff bundles on the rising edge of in_strobe, buffers them and
// streams each one out element by element (col = 0..size-1).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_strobe, is_update       : bundle offer (rising edge) and keep flag
//   w_layer_index .. diff_cost : bundle scalars and vectors
//   out_valid/out_ready        : beat handshake; out_last marks col size-1
//   out_col .. out_cost        : element beat (all zero while idle)
//   overflow                   : sticky, set when a bundle is dropped
//   busy                       : buffer non-empty or emitting
// Optional: define DIFF_BACKPROP_RX_STATS_EN to add emitted_count and
// dropped_count (16-bit, saturating).
module diff_backprop_rx
  import diff_backprop_pkg::*;
#(
  parameter int unsigned size            = 3,
  parameter int unsigned data_size       = 16,
  parameter int unsigned dense_type_size = 4,
  parameter int unsigned depth           = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_strobe,
  input  logic [31:0]                   w_layer_index,
  input  logic [31:0]                   w_row_index,
  input  logic                          backprop_cost,
  input  logic [31:0]                   dense_type,
  input  logic                          is_update,
  input  logic [size*data_size-1:0]     diff_to_all,
  input  logic [size*data_size-1:0]     diff_start,
  input  logic [size*data_size-1:0]     diff_dense,
  input  logic [size*data_size-1:0]     diff_cost,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [31:0]                   out_col,
  output logic [31:0]                   out_layer,
  output logic [31:0]                   out_row,
  output logic                          out_backprop_cost,
  output logic [dense_type_size-1:0]    out_dense_type,
  output logic [data_size-1:0]          out_to_all,
  output logic [data_size-1:0]          out_start,
  output logic [data_size-1:0]          out_dense,
  output logic [data_size-1:0]          out_cost,
  output logic                          overflow,
  output logic                          busy
`ifdef DIFF_BACKPROP_RX_STATS_EN
  ,
  output logic [15:0]                   emitted_count,
  output logic [15:0]                   dropped_count
`endif
);

  localparam int unsigned VecW   = size * data_size;
  localparam int unsigned EntryW = $bits(bundle_t) + 4 * VecW;
  localparam int unsigned ColW   = (size > 1) ? $clog2(size) : 1;
  localparam int unsigned CntW   = $clog2(depth + 1);
  localparam logic [ColW-1:0] LastCol = ColW'(size - 1);

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic            strobe_q, armed_q, overflow_q;

  logic            strobe_edge, offer, push, pop, drop, accept, last_beat, more;
  logic            full, empty;
  logic [CntW-1:0] count;
  logic [EntryW-1:0] wdata, rdata;
  bundle_t         in_hdr, head_hdr;
  logic [VecW-1:0] head_to_all, head_start, head_dense, head_cost;

  // armed_q stays low after reset until in_strobe is seen low, so a strobe
  // held high across reset release is not taken as a new edge.
  assign strobe_edge = in_strobe & ~strobe_q & armed_q;
  assign offer       = strobe_edge & is_update;

  assign out_valid = (state_q == StEmit);
  assign accept    = out_valid & out_ready;
  assign last_beat = (col_q == LastCol);
  assign pop       = accept & last_beat;
  assign push      = offer & (~full | pop);
  assign drop      = offer & full & ~pop;
  // Another entry remains after the current pop (possibly the one pushed now).
  assign more      = (count > CntW'(1)) | push;

  assign in_hdr = '{layer: w_layer_index, row: w_row_index,
                    backprop_cost: backprop_cost, dense_type: dense_type};
  assign wdata  = {in_hdr, diff_to_all, diff_start, diff_dense, diff_cost};
  assign {head_hdr, head_to_all, head_start, head_dense, head_cost} = rdata;

  diff_backprop_fifo #(
    .depth (depth),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      strobe_q   <= 1'b0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= in_strobe;
      armed_q  <= armed_q | ~in_strobe;
      if (drop) overflow_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q <= StEmit;
            col_q   <= '0;
          end
        end
        StEmit: begin
          if (accept) begin
            if (last_beat) begin
              col_q <= '0;
              if (!more) state_q <= StIdle;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign overflow = overflow_q;
  assign busy     = ~empty | (state_q == StEmit);

  always_comb begin
    out_last          = 1'b0;
    out_col           = '0;
    out_layer         = '0;
    out_row           = '0;
    out_backprop_cost = 1'b0;
    out_dense_type    = '0;
    out_to_all        = '0;
    out_start         = '0;
    out_dense         = '0;
    out_cost          = '0;
    if (out_valid) begin
      out_last          = last_beat;
      out_col           = 32'(col_q);
      out_layer         = head_hdr.layer;
      out_row           = head_hdr.row;
      out_backprop_cost = head_hdr.backprop_cost;
      out_dense_type    = head_hdr.dense_type[dense_type_size-1:0];
      out_to_all        = head_to_all[col_q*data_size +: data_size];
      out_start         = head_start[col_q*data_size +: data_size];
      out_dense         = head_dense[col_q*data_size +: data_size];
      out_cost          = head_cost[col_q*data_size +: data_size];
    end
  end

  logic unused_dense_hi;
  assign unused_dense_hi = ^head_hdr.dense_type[31:dense_type_size];

`ifdef DIFF_BACKPROP_RX_STATS_EN
  logic [15:0] emitted_q, dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      emitted_q <= '0;
      dropped_q <= '0;
    end else begin
      if (pop && emitted_q != 16'hFFFF)  emitted_q <= emitted_q + 16'd1;
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign emitted_count = emitted_q;
  assign dropped_count = dropped_q;
`endif

endmodule

// File: tb/tb_diff_backprop_rx.sv
module tb_diff_backprop_rx;

  localparam int SIZE  = 3;
  localparam int DW    = 16;
  localparam int DTS   = 4;
  localparam int DEPTH = 2;
  localparam int VecW  = SIZE * DW;

  typedef struct packed {
    logic [31:0]     layer;
    logic [31:0]     row;
    logic [31:0]     dt;
    logic            bc;
    logic [VecW-1:0] to_all;
    logic [VecW-1:0] start;
    logic [VecW-1:0] dense;
    logic [VecW-1:0] cost;
  } bundle_s;

  typedef struct packed {
    logic [31:0]    col;
    logic           last;
    logic [31:0]    layer;
    logic [31:0]    row;
    logic           bc;
    logic [DTS-1:0] dt;
    logic [DW-1:0]  to_all;
    logic [DW-1:0]  start;
    logic [DW-1:0]  dense;
    logic [DW-1:0]  cost;
  } beat_s;

  logic clk = 1'b0;
  logic reset, in_strobe, backprop_cost, is_update, out_ready;
  logic [31:0] w_layer_index, w_row_index, dense_type;
  logic [VecW-1:0] diff_to_all, diff_start, diff_dense, diff_cost;
  logic out_valid, out_last, out_backprop_cost, overflow, busy;
  logic [31:0] out_col, out_layer, out_row;
  logic [DTS-1:0] out_dense_type;
  logic [DW-1:0] out_to_all, out_start, out_dense, out_cost;
`ifdef DIFF_BACKPROP_RX_STATS_EN
  logic [15:0] emitted_count, dropped_count;
`endif

  always #5 clk = ~clk;

  diff_backprop_rx #(
    .size            (SIZE),
    .data_size       (DW),
    .dense_type_size (DTS),
    .depth           (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_strobe         (in_strobe),
    .w_layer_index     (w_layer_index),
    .w_row_index       (w_row_index),
    .backprop_cost     (backprop_cost),
    .dense_type        (dense_type),
    .is_update         (is_update),
    .diff_to_all       (diff_to_all),
    .diff_start        (diff_start),
    .diff_dense        (diff_dense),
    .diff_cost         (diff_cost),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .out_col           (out_col),
    .out_layer         (out_layer),
    .out_row           (out_row),
    .out_backprop_cost (out_backprop_cost),
    .out_dense_type    (out_dense_type),
    .out_to_all        (out_to_all),
    .out_start         (out_start),
    .out_dense         (out_dense),
    .out_cost          (out_cost),
    .overflow          (overflow),
    .busy              (busy)
`ifdef DIFF_BACKPROP_RX_STATS_EN
    ,
    .emitted_count     (emitted_count),
    .dropped_count     (dropped_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int exp_emitted = 0;
  beat_s exp_q[$];
  bundle_s tv[4];
  beat_s mon_act, mon_exp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_bundle(input bundle_s b, input int n);
    beat_s e;
    for (int i = 0; i < n; i++) begin
      e.col    = 32'(i);
      e.last   = (i == SIZE - 1);
      e.layer  = b.layer;
      e.row    = b.row;
      e.bc     = b.bc;
      e.dt     = b.dt[DTS-1:0];
      e.to_all = b.to_all[i*DW +: DW];
      e.start  = b.start[i*DW +: DW];
      e.dense  = b.dense[i*DW +: DW];
      e.cost   = b.cost[i*DW +: DW];
      exp_q.push_back(e);
    end
    if (n == SIZE) exp_emitted++;
  endfunction

  function automatic beat_s cur_beat();
    beat_s a;
    a = '{col: out_col, last: out_last, layer: out_layer, row: out_row,
          bc: out_backprop_cost, dt: out_dense_type, to_all: out_to_all,
          start: out_start, dense: out_dense, cost: out_cost};
    return a;
  endfunction

  // Scoreboard: every accepted beat must match the next expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beats++;
      mon_act = cur_beat();
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 256'(mon_act), 256'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 256'(mon_act), 256'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bundle_s b, input logic upd);
    w_layer_index = b.layer;
    w_row_index   = b.row;
    dense_type    = b.dt;
    backprop_cost = b.bc;
    diff_to_all   = b.to_all;
    diff_start    = b.start;
    diff_dense    = b.dense;
    diff_cost     = b.cost;
    is_update     = upd;
    in_strobe     = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", 256'(exp_q.size()), 256'(0));
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({out_valid, out_last, busy, overflow, out_col, out_layer, out_row,
                 out_backprop_cost, out_dense_type, out_to_all, out_start, out_dense, out_cost});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic busy_seen;
    beat_s snap;
    int n;

    tv[0] = '{layer: 32'd1, row: 32'd10, dt: 32'hFFFF_FFF5, bc: 1'b1,
              to_all: {16'h0A03, 16'h0A02, 16'h0A01}, start: {16'h0B03, 16'h0B02, 16'h0B01},
              dense: {16'h0C03, 16'h0C02, 16'h0C01}, cost: {16'h0003, 16'h0002, 16'h0001}};
    tv[1] = '{layer: 32'd7, row: 32'd3, dt: 32'h0000_000C, bc: 1'b0,
              to_all: {16'hFFFF, 16'h0000, 16'h8000}, start: {16'h1234, 16'h5678, 16'h9ABC},
              dense: {16'h0001, 16'h0010, 16'h0100}, cost: {16'hDEAD, 16'hBEEF, 16'hCAFE}};
    tv[2] = '{layer: 32'hFFFF_FFFF, row: 32'h8000_0000, dt: 32'h1234_5670, bc: 1'b1,
              to_all: {16'h1111, 16'h2222, 16'h3333}, start: {16'h4444, 16'h5555, 16'h6666},
              dense: {16'h7777, 16'h8888, 16'h9999}, cost: {16'hAAAA, 16'hBBBB, 16'hCCCC}};
    tv[3] = '{layer: 32'd0, row: 32'd0, dt: 32'd15, bc: 1'b0,
              to_all: {16'h0F00, 16'h00F0, 16'h000F}, start: {16'h0300, 16'h0030, 16'h0003},
              dense: {16'h5A5A, 16'hA5A5, 16'h5A5A}, cost: {16'h7FFF, 16'h8001, 16'h0000}};

    reset = 1'b1; in_strobe = 1'b0; is_update = 1'b0; out_ready = 1'b1;
    backprop_cost = 1'b0; w_layer_index = '0; w_row_index = '0; dense_type = '0;
    diff_to_all = '0; diff_start = '0; diff_dense = '0; diff_cost = '0;

    step(); step();
    check("reset_outs_during", all_outs(), 256'(0));
    reset = 1'b0;
    step(); step();
    check("reset_outs_after", all_outs(), 256'(0));

    // Single bundles with ready=1: latency and element order.
    for (int t = 0; t < 4; t++) begin
      drive(tv[t], 1'b1);
      push_bundle(tv[t], SIZE);
      step();
      in_strobe = 1'b0;
      check("latency_edge1", 256'(out_valid), 256'(0));
      step();
      check("latency_edge2", 256'(out_valid), 256'(1));
      wait_drain(20);
      step();
      check("idle_busy", 256'(busy), 256'(0));
    end
    check("no_overflow", 256'(overflow), 256'(0));

    // Strobe held high for 10 cycles captures once.
    b0 = beats;
    drive(tv[0], 1'b1);
    push_bundle(tv[0], SIZE);
    for (int i = 0; i < 10; i++) step();
    in_strobe = 1'b0;
    wait_drain(20);
    step(); step(); step();
    check("held_beats", 256'(beats - b0), 256'(SIZE));
`ifdef DIFF_BACKPROP_RX_STATS_EN
    check("emitted_count", 256'(emitted_count), 256'(exp_emitted));
`endif

    // is_update=0 is discarded.
    b0 = beats;
    busy_seen = 1'b0;
    drive(tv[1], 1'b0);
    step();
    in_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      busy_seen |= busy;
      step();
    end
    check("discard_beats", 256'(beats - b0), 256'(0));
    check("discard_busy", 256'(busy_seen), 256'(0));
    check("discard_overflow", 256'(overflow), 256'(0));

    // Overflow: two buffered, third dropped while stalled.
    b0 = beats;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(tv[k + 1], 1'b1);
      if (k < DEPTH) push_bundle(tv[k + 1], SIZE);
      step();
      in_strobe = 1'b0;
      step();
    end
    check("overflow_set", 256'(overflow), 256'(1));
    check("overflow_busy", 256'(busy), 256'(1));
`ifdef DIFF_BACKPROP_RX_STATS_EN
    check("dropped_count", 256'(dropped_count), 256'(1));
`endif
    out_ready = 1'b1;
    wait_drain(40);
    step(); step();
    check("overflow_beats", 256'(beats - b0), 256'(2 * SIZE));
    check("overflow_sticky", 256'(overflow), 256'(1));

    // Stall with ready 1,0,0,1: outputs frozen, no skip or duplicate.
    drive(tv[3], 1'b1);
    push_bundle(tv[3], SIZE);
    step();
    in_strobe = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("stall_valid", 256'(out_valid), 256'(1));
    step();
    out_ready = 1'b0;
    snap = cur_beat();
    step();
    check("stall_hold1", 256'(cur_beat()), 256'(snap));
    step();
    check("stall_hold2", 256'(cur_beat()), 256'(snap));
    check("stall_col", 256'(out_col), 256'(1));
    out_ready = 1'b1;
    wait_drain(20);
    step();

    // Reset after the first beat; strobe held high across release.
    b0 = beats;
    drive(tv[2], 1'b1);
    push_bundle(tv[2], 1);
    step();
    in_strobe = 1'b0;
    step();
    step();
    reset = 1'b1;
    in_strobe = 1'b1;
    step();
    check("midrst_valid", 256'(out_valid), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_overflow", 256'(overflow), 256'(0));
    reset = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      busy_seen |= busy;
    end
    check("midrst_beats", 256'(beats - b0), 256'(1));
    check("midrst_no_capture", 256'(busy_seen), 256'(0));
    check("midrst_queue", 256'(exp_q.size()), 256'(0));
    in_strobe = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
